// File: rtl/cpu_pkg.sv
// Shared encodings for the CR16-style multicycle control unit: FSM states,
// opcode/ext constants, condition codes, flag indices and write-data selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_CMP   = 4'b0000;
  localparam logic [3:0] OP_MISC  = 4'b0100;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_CMP   = 4'b1011;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam logic [1:0] WSEL_ALU  = 2'b00;
  localparam logic [1:0] WSEL_MDR  = 2'b01;
  localparam logic [1:0] WSEL_LINK = 2'b10;

  typedef struct packed {
    logic load;
    logic stor;
    logic jal;
    logic jcond;
    logic bcond;
    logic cmp;
  } instr_class_t;

  // Anything not matched here is an ordinary ALU operation.
  function automatic instr_class_t classify(input logic [3:0] opcode, input logic [3:0] ext);
    instr_class_t c;
    c       = '0;
    c.load  = (opcode == OP_MISC) && (ext == EXT_LOAD);
    c.stor  = (opcode == OP_MISC) && (ext == EXT_STOR);
    c.jal   = (opcode == OP_MISC) && (ext == EXT_JAL);
    c.jcond = (opcode == OP_MISC) && (ext == EXT_JCOND);
    c.bcond = (opcode == OP_BCOND);
    c.cmp   = ((opcode == OP_CMP) && (ext == EXT_CMP)) || (opcode == OP_CMPI);
    return c;
  endfunction

endpackage

// File: rtl/cpu_sequencer_cond_eval.sv
// Condition-code evaluator: decides whether a Bcond/Jcond is taken from the
// 4-bit condition field and the {C,L,F,Z,N} flag register.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic f_c, f_l, f_f, f_z, f_n;

  always_comb begin
    f_c = flags[FLAG_C];
    f_l = flags[FLAG_L];
    f_f = flags[FLAG_F];
    f_z = flags[FLAG_Z];
    f_n = flags[FLAG_N];
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = f_z;
      COND_NE: taken = ~f_z;
      COND_CS: taken = f_c;
      COND_CC: taken = ~f_c;
      COND_HI: taken = f_l;
      COND_LS: taken = ~f_l;
      COND_GT: taken = f_n;
      COND_LE: taken = ~f_n;
      COND_FS: taken = f_f;
      COND_FC: taken = ~f_f;
      COND_LO: taken = ~f_l & ~f_z;
      COND_HS: taken = f_l | f_z;
      COND_LT: taken = ~f_n & ~f_z;
      COND_GE: taken = f_n | f_z;
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle control unit: owns pc/ir/mdr and sequences fetch, decode,
// execute, memory and writeback against a variable-latency memory handshake.
//
//   state  | meaning
//   FETCH  | request instruction at pc, wait for mem_ready
//   DECODE | one settle cycle for register-file read, then dispatch
//   EXEC   | ALU/CMP/branch/jump/JAL strobes and pc update
//   MEM    | load/store request at rsrc_val, wait for mem_ready
//   WB     | write mdr into the destination register
//   HALT   | absorbing until reset, all strobes low
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                REG_SEL_W = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_ready,
  input  logic [4:0]           alu_flags,
  input  logic [DATA_W-1:0]    rsrc_val,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    ir,
  output logic [DATA_W-1:0]    mdr,
  output logic [ADDR_W-1:0]    pc,
  output logic [DATA_W-1:0]    link,
  output logic                 rf_we,
  output logic [REG_SEL_W-1:0] rf_wsel,
  output logic [1:0]           rf_wdata_sel,
  output logic                 flags_we,
  output logic                 halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;

  instr_class_t      cls;
  logic              cond_taken;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] link_addr;
  logic [ADDR_W-1:0] disp_sext;
  logic [ADDR_W-1:0] rsrc_addr;
  logic [ADDR_W-1:0] branch_target;

  cond_eval u_cond_eval (
    .cond  (ir_q[11:8]),
    .flags (alu_flags),
    .taken (cond_taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ipc_q   <= RESET_PC;
      ir_q    <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
    end
  end

  // All address arithmetic lands in ADDR_W-wide nets so it wraps naturally.
  always_comb begin
    cls           = classify(ir_q[15:12], ir_q[7:4]);
    pc_inc        = pc_q + ADDR_W'(1);
    link_addr     = ipc_q + ADDR_W'(1);
    disp_sext     = ADDR_W'(signed'(ir_q[7:0]));
    branch_target = ipc_q + disp_sext;
    rsrc_addr     = ADDR_W'(rsrc_val);
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ipc_d        = ipc_q;
    ir_d         = ir_q;
    mdr_d        = mdr_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = pc_q;
    rf_we        = 1'b0;
    rf_wdata_sel = WSEL_ALU;
    flags_we     = 1'b0;
    halted       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_inc;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (&ir_q)                      state_d = ST_HALT;
        else if (cls.load || cls.stor)  state_d = ST_MEM;
        else                            state_d = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        if (cls.bcond) begin
          if (cond_taken) pc_d = branch_target;
        end else if (cls.jcond) begin
          if (cond_taken) pc_d = rsrc_addr;
        end else if (cls.jal) begin
          rf_we        = 1'b1;
          rf_wdata_sel = WSEL_LINK;
          pc_d         = rsrc_addr;
        end else if (cls.cmp) begin
          flags_we = 1'b1;
        end else begin
          rf_we    = 1'b1;
          flags_we = 1'b1;
        end
      end

      // Store data is driven by the datapath from register ir[11:8].
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = rsrc_addr;
        mem_we   = cls.stor;
        if (mem_ready) begin
          if (cls.stor) begin
            state_d = ST_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        rf_we        = 1'b1;
        rf_wdata_sel = WSEL_MDR;
        state_d      = ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: state_d = ST_FETCH;
    endcase
  end

  assign ir      = ir_q;
  assign mdr     = mdr_q;
  assign pc      = pc_q;
  assign link    = DATA_W'(link_addr);
  assign rf_wsel = REG_SEL_W'(ir_q[11:8]);

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised multicycle control unit for the 16-bit CR16-style CPU, replacing the fixed three-signal control FSM. It owns the program counter, instruction register and memory data register. It sequences fetch/decode/execute/memory/writeback against a variable-latency memory handshake, and adds loads, stores, conditional branches, conditional jumps, jump-and-link and halt. The register file, ALU and flag register remain in the datapath; this block drives their enables and write-select.

## Interface
Clock is `clk`; reset is `reset`, synchronous and active-high.

Parameters:
- `DATA_W`, 16: instruction, register and memory word width (≥16).
- `ADDR_W`, 16: memory address and PC width.
- `REG_SEL_W`, 4: register-select width (2^REG_SEL_W registers).
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `mem_rdata`  in  DATA_W  read data. Valid when `mem_ready` is high.
- `mem_ready`  in  1  memory completes the current request at this edge.
- `alu_flags`  in  5  {C,L,F,Z,N}, bits 4..0, from the flag register.
- `rsrc_val`  in  DATA_W  value of register ir[3:0]: load/store address, jump target.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write (store); meaningful only with `mem_req`.
- `mem_addr`  out  ADDR_W  request address.
- `ir`  out  DATA_W  instruction register.
- `mdr`  out  DATA_W  memory data register.
- `pc`  out  ADDR_W  program counter.
- `link`  out  DATA_W  address of the current instruction + 1, zero-extended or truncated to DATA_W.
- `rf_we`  out  1  register write strobe.
- `rf_wsel`  out  REG_SEL_W  destination register, ir[11:8].
- `rf_wdata_sel`  out  2  write-data source: 00 ALU, 01 `mdr`, 10 `link`.
- `flags_we`  out  1  flag register update strobe.
- `halted`  out  1  block is in the HALT state.

## Operation
- Instruction fields:
  - opcode = ir[15:12]
  - Rdest/cond = ir[11:8]
  - ext = ir[7:4]
  - Rsrc = ir[3:0]
  - disp = ir[7:0]
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are Moore-decoded from the state and registers.
- FETCH:
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`=pc.
  - On an edge with `mem_ready`: ir←mem_rdata, ipc←pc, pc←pc+1, state←DECODE.
  - Otherwise stays in FETCH.
- DECODE: one cycle, for register-file read settle, then dispatch:
  - ir all-ones → HALT.
  - opcode 0100, ext 0000 (LOAD) → MEM.
  - opcode 0100, ext 0100 (STOR) → MEM.
  - Everything else → EXEC.
- EXEC:
  - Bcond (opcode 1100): if cond is true, pc←ipc+sext(disp).
  - Jcond (0100/1100): if cond is true, pc←rsrc_val[ADDR_W-1:0].
  - JAL (0100/1000): `rf_we`=1, `rf_wdata_sel`=10, pc←rsrc_val.
  - CMP (0000/1011) and CMPI (1011): `flags_we`=1, `rf_we`=0.
  - All other opcodes are ALU ops: `rf_we`=1, `rf_wdata_sel`=00, `flags_we`=1.
  - Next state: FETCH.
- MEM:
  - Drives `mem_req`=1, `mem_addr`=rsrc_val[ADDR_W-1:0], `mem_we`=1 for STOR.
  - Store data comes from the datapath (register ir[11:8]).
  - On an edge with `mem_ready`: LOAD captures mdr←mem_rdata and goes to WB; STOR goes to FETCH.
- WB: `rf_we`=1, `rf_wdata_sel`=01, then FETCH.
- HALT:
  - Absorbing until reset.
  - `halted`=1.
  - All strobes, including `mem_req`, are 0.
- Condition codes (4-bit cond):
  - 0 EQ Z; 1 NE !Z
  - 2 CS C; 3 CC !C
  - 4 HI L; 5 LS !L
  - 6 GT N; 7 LE !N
  - 8 FS F; 9 FC !F
  - A LO !L&!Z; B HS L|Z
  - C LT !N&!Z; D GE N|Z
  - E UC 1; F never.
- Arithmetic:
  - PC arithmetic is modulo 2^ADDR_W; pc+1 at the maximum wraps to 0.
  - disp is sign-extended from 8 bits to ADDR_W.
  - rsrc_val is truncated to ADDR_W when used as an address.
- `mem_ready` is ignored outside FETCH and MEM.

## Timing
- Reset:
  - state=FETCH, pc=RESET_PC, ir=0, mdr=0, ipc=RESET_PC.
  - Outputs in FETCH after reset: `mem_req`=1, `mem_addr`=RESET_PC. All other strobes 0, `halted`=0.
- Reset mid-operation (any state, including while waiting on `mem_ready`): reset wins at that edge. The outstanding request is abandoned and the memory must tolerate this.
- Minimum latencies with `mem_ready` high in the first request cycle:
  - ALU, CMP, branch, jump, JAL: 3 cycles (FETCH, DECODE, EXEC).
  - STOR: 3 cycles (FETCH, DECODE, MEM).
  - LOAD: 4 cycles (FETCH, DECODE, MEM, WB).
  - Each memory wait cycle adds 1.
- Request stability: `mem_req`, `mem_addr` and `mem_we` are held stable from assertion until the edge at which `mem_ready` is sampled high.
- Strobe and PC timing:
  - `rf_we` and `flags_we` are single-cycle pulses.
  - A taken-branch or jump PC update is visible the cycle after EXEC, in the next FETCH's `mem_addr`.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum
  - opcode/ext constants (LOAD, STOR, JAL, JCOND, BCOND, CMP, CMPI)
  - condition-code constants
  - flag bit indices C=4, L=3, F=2, Z=1, N=0
  - `rf_wdata_sel` encodings
- One combinational sub-module, `cond_eval`: inputs cond[3:0] and flags[4:0], output taken.

## Test plan
- Reset with RESET_PC=0x0010 → `mem_req`=1, `mem_addr`=0x0010, `halted`=0. After `mem_ready`, pc=0x0011.
- ALU word 0x0512 (ADD) with immediate ready → `rf_we` and `flags_we` pulse in cycle 3, `rf_wsel`=5. Next fetch at pc+1.
- LOAD 0x4003 with rsrc_val=0x0200 and a 3-cycle memory wait, mem_rdata=0xBEEF → `mdr`=0xBEEF, WB asserts `rf_wdata_sel`=01. Total 7 cycles.
- Branch 0xC0FE (EQ, disp −2) at address 0x0008:
  - Z=1 → next `mem_addr`=0x0006.
  - Z=0 → next `mem_addr`=0x0009.
- JAL 0x4E83 at 0x0020 with rsrc_val=0x0100 → `rf_wdata_sel`=10, `link`=0x0021, next fetch 0x0100. PC at 0xFFFF with a non-branch → next fetch 0x0000.
- Fetch of 0xFFFF → HALT, `halted`=1, no `mem_req`. Reset asserted during a MEM wait → FETCH at RESET_PC the next cycle.
